// File: rtl/unsigned_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unsigned_div_pkg
// Description : Shared widths, state encoding, error response constants and
//               the overflow predicate for the sequential 16/8 unsigned
//               restoring divider.
// Contents    : DIVIDEND_W, DIVISOR_W, STEPS, CNT_W, CNT_INIT,
//               ERR_QUOTIENT, ERR_REMAINDER, state_e, div_overflow()
// Revision    : 1.0 - initial release
// ============================================================================
package unsigned_div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int STEPS      = 8;
  localparam int CNT_W      = $clog2(STEPS);

  // Counter counts down to zero, so a full run of STEPS starts at STEPS-1.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS - 1);

  localparam logic [DIVISOR_W-1:0] ERR_QUOTIENT  = 8'hFF;
  localparam logic [DIVISOR_W-1:0] ERR_REMAINDER = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // The quotient fits in DIVISOR_W bits only when the upper half of the
  // dividend is strictly below the divisor; a zero divisor is caught by the
  // same comparison but is listed explicitly for readability.
  function automatic logic div_overflow(
    input logic [DIVIDEND_W-1:0] dvd,
    input logic [DIVISOR_W-1:0]  dvs
  );
    return (dvs == '0) || (dvd[DIVIDEND_W-1:DIVISOR_W] >= dvs);
  endfunction

endpackage : unsigned_div_pkg
`default_nettype wire

// File: rtl/unsigned_div_step.sv
`default_nettype none
// ============================================================================
// Module      : unsigned_div_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit into the partial remainder, compares against
//               the divisor with a 9-bit comparison and subtracts when the
//               shifted value is large enough.
// Ports       : rem_i     [7:0] partial remainder (always < divisor_i)
//               dbit_i          next dividend bit, MSB first
//               divisor_i [7:0] divisor
//               rem_o     [7:0] new partial remainder
//               qbit_o          resulting quotient bit
// Revision    : 1.0 - initial release
// ============================================================================
module unsigned_div_step
  import unsigned_div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 dbit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] rem_o,
  output logic                 qbit_o
);

  logic [DIVISOR_W:0]   trial;
  logic [DIVISOR_W-1:0] diff;

  // The shifted value needs the extra bit: with a divisor above 8'h80 the
  // incoming remainder can exceed 8'h7F, so trial[8] may be set.
  assign trial  = {rem_i, dbit_i};
  assign qbit_o = (trial >= {1'b0, divisor_i});

  // When the subtraction is taken the true result is below the divisor and
  // therefore fits in 8 bits, so a modulo-256 subtract on the low bits is
  // exact and the carry out of bit 8 never matters.
  assign diff  = trial[DIVISOR_W-1:0] - divisor_i;
  assign rem_o = qbit_o ? diff : trial[DIVISOR_W-1:0];

endmodule : unsigned_div_step
`default_nettype wire

// File: rtl/unsigned_divider_16by8_seq.sv
`default_nettype none
// ============================================================================
// Module      : unsigned_divider_16by8_seq
// Description : Sequential unsigned 16/8 restoring divider, one quotient bit
//               per cycle, valid/ready handshakes on both sides. Divide by
//               zero and quotient overflow are flagged at accept and answered
//               immediately with err=1 and all-ones quotient/remainder.
// Ports       : clk, rst         clock, synchronous active-high reset
//               in_valid/in_ready  operand handshake
//               dividend  [15:0]   unsigned dividend
//               divisor   [7:0]    unsigned divisor
//               out_valid/out_ready result handshake
//               quotient  [7:0]    unsigned quotient
//               remainder [7:0]    unsigned remainder
//               err                divide by zero or quotient overflow
// Revision    : 1.0 - initial release
// ============================================================================
module unsigned_divider_16by8_seq
  import unsigned_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  err
);

  state_e               state_q, state_d;
  logic [DIVISOR_W-1:0] rem_q, rem_d;
  // Holds the unconsumed low dividend bits at the top and collects quotient
  // bits at the bottom; after the last step it is the full quotient.
  logic [DIVISOR_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 out_valid_q, out_valid_d;

  logic [DIVISOR_W-1:0] step_rem;
  logic                 step_qbit;
  logic                 overflow;

  unsigned_div_step u_step (
    .rem_i     (rem_q),
    .dbit_i    (quo_q[DIVISOR_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  assign overflow = div_overflow(dividend, divisor);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (overflow) begin
            rem_d       = ERR_REMAINDER;
            quo_d       = ERR_QUOTIENT;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            rem_d   = dividend[DIVIDEND_W-1:DIVISOR_W];
            quo_d   = dividend[DIVISOR_W-1:0];
            dvs_d   = divisor;
            cnt_d   = CNT_INIT;
            err_d   = 1'b0;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[DIVISOR_W-2:0], step_qbit};
        if (cnt_q == '0) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  // out_valid comes straight from a flop so it cannot glitch; quotient and
  // remainder are only written in IDLE and CALC, so they hold in DONE.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign err       = err_q;

endmodule : unsigned_divider_16by8_seq
`default_nettype wire

// File: tb/tb_unsigned_divider_16by8_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_unsigned_divider_16by8_seq
// Description : Self-checking bench for unsigned_divider_16by8_seq. Directed
//               vectors with hand-computed results, stall, mid-run reset and
//               a randomised sweep checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unsigned_divider_16by8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  unsigned_divider_16by8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Directed operation. Inputs change on the falling edge and outputs are
  // sampled on the falling edge; latency counts falling edges after the
  // accepting rising edge.
  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs,
                        input logic [7:0] exp_q, input logic [7:0] exp_r,
                        input logic exp_err, input logic hold_ready,
                        input int stall);
    int lat;
    @(negedge clk);
    check_eq("in_ready_before_accept", in_ready, 1);
    in_valid  = 1'b1;
    dividend  = dvd;
    divisor   = dvs;
    out_ready = hold_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check_eq("in_ready_busy", in_ready, 0);
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check_eq("latency", lat, exp_err ? 1 : 9);
    check_eq("quotient", quotient, exp_q);
    check_eq("remainder", remainder, exp_r);
    check_eq("err", err, exp_err);
    check_eq("in_ready_done", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_quotient", quotient, exp_q);
      check_eq("stall_remainder", remainder, exp_r);
      check_eq("stall_err", err, exp_err);
      check_eq("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("out_valid_after_hs", out_valid, 0);
    check_eq("in_ready_after_hs", in_ready, 1);
    out_ready = 1'b0;
  endtask

  // Randomised operation with a randomly toggling out_ready and a reference
  // result from the language's own division operators.
  task automatic rand_op(input logic [15:0] dvd, input logic [7:0] dvs);
    logic [7:0] exp_q, exp_r;
    logic       exp_err;
    int         lat;
    bit         first, done;
    exp_err = (dvs == 8'h00) || (dvd[15:8] >= dvs);
    if (exp_err) begin
      exp_q = 8'hFF;
      exp_r = 8'hFF;
    end else begin
      exp_q = 8'(dvd / {8'h00, dvs});
      exp_r = 8'(dvd % {8'h00, dvs});
    end
    @(negedge clk);
    check_eq("rnd_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    dividend  = dvd;
    divisor   = dvs;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    lat   = 0;
    first = 1'b1;
    done  = 1'b0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      if (out_valid) begin
        if (first) begin
          check_eq("rnd_latency", lat, exp_err ? 1 : 9);
          if (!exp_err) begin
            check_eq("rnd_invariant", 32'(quotient) * 32'(dvs) + 32'(remainder), 32'(dvd));
            check_eq("rnd_rem_lt_div", remainder < dvs, 1);
          end
          first = 1'b0;
        end
        check_eq("rnd_quotient", quotient, exp_q);
        check_eq("rnd_remainder", remainder, exp_r);
        check_eq("rnd_err", err, exp_err);
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) done = 1'b1;
    end
    if (!done) check_eq("rnd_timeout", 0, 1);
    @(negedge clk);
    check_eq("rnd_out_valid_cleared", out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] rdvd;
    logic [7:0]  rdvs;

    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = 16'h0000;
    divisor   = 8'h00;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_quotient", quotient, 0);
    check_eq("rst_remainder", remainder, 0);
    check_eq("rst_err", err, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 0xC3 * 0x5A = 0x448E, exact and with the largest possible remainder.
    run_op(16'h448E, 8'h5A, 8'hC3, 8'h00, 1'b0, 1'b0, 0);
    run_op(16'h44E7, 8'h5A, 8'hC3, 8'h59, 1'b0, 1'b1, 0);
    // 0xFF * 0xFF: shifted remainder exceeds 8 bits on several steps.
    run_op(16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 0);
    // 32767 = 255*128 + 127, largest non-overflowing case for 0x80.
    run_op(16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0, 0);
    run_op(16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    run_op(16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 0);
    // Error path: upper byte equal to divisor, and divide by zero.
    run_op(16'h1234, 8'h12, 8'hFF, 8'hFF, 1'b1, 1'b0, 0);
    run_op(16'h0005, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1, 0);
    // Stall in DONE for 20 cycles.
    run_op(16'h44E7, 8'h5A, 8'hC3, 8'h59, 1'b0, 1'b0, 20);
    run_op(16'h1234, 8'h12, 8'hFF, 8'hFF, 1'b1, 1'b0, 20);

    // Reset while in CALC discards the partial result.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'h448E;
    divisor  = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("calc_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_quotient", quotient, 0);
    check_eq("midrst_remainder", remainder, 0);
    check_eq("midrst_err", err, 0);
    run_op(16'h448E, 8'h5A, 8'hC3, 8'h00, 1'b0, 1'b0, 0);

    // Random sweep, biased so most operations avoid the overflow path.
    for (int n = 0; n < 2000; n++) begin
      rdvs = 8'($urandom);
      if (rdvs != 8'h00 && $urandom_range(0, 3) != 0)
        rdvd = {8'($urandom_range(0, 32'(rdvs) - 1)), 8'($urandom)};
      else
        rdvd = 16'($urandom);
      rand_op(rdvd, rdvs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_unsigned_divider_16by8_seq
`default_nettype wire
